multicycle_maindec: RTL and testbench

- Main control FSM for the multicycle MIPS datapath; the next generation of the single-cycle main decoder.
- Sequences each instruction through fetch, decode, execute, memory and writeback states, and drives Moore control signals to the shared-memory datapath.
- Adds ANDI, separates BEQ from BNE, adds a memory wait handshake, and flags illegal opcodes.
- Sits between the instruction register (op) and the datapath, next to the ALU decoder.

---
 rtl/mips_pkg.sv | 46 ++++
 rtl/multicycle_maindec.sv | 158 +++++++++++++++
 tb/tb_multicycle_maindec.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path: opcodes, datapath
// select codes and the main controller state encoding.
package mips_pkg;

  localparam logic [5:0] RTYPE = 6'b000000;
  localparam logic [5:0] LW    = 6'b100011;
  localparam logic [5:0] SW    = 6'b101011;
  localparam logic [5:0] BEQ   = 6'b000100;
  localparam logic [5:0] BNE   = 6'b000101;
  localparam logic [5:0] ADDI  = 6'b001000;
  localparam logic [5:0] ORI   = 6'b001101;
  localparam logic [5:0] ANDI  = 6'b001100;
  localparam logic [5:0] J     = 6'b000010;

  localparam logic [2:0] ALUOP_ADD   = 3'd0;
  localparam logic [2:0] ALUOP_SUB   = 3'd1;
  localparam logic [2:0] ALUOP_OR    = 3'd2;
  localparam logic [2:0] ALUOP_AND   = 3'd3;
  localparam logic [2:0] ALUOP_FUNCT = 3'd4;

  localparam logic [1:0] ALUSRCB_REGB  = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
  localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_LOGIEX  = 4'd10,
    S_IMMWB   = 4'd11,
    S_JUMP    = 4'd12
  } state_t;

endpackage

// File: rtl/multicycle_maindec.sv
// Main control FSM of the multicycle MIPS datapath: sequences each instruction
// through its states and decodes Moore control signals from the current state.
module multicycle_maindec
  import mips_pkg::*;
#(
  parameter int ALUOP_W  = 3,
  parameter bit MEM_WAIT = 1'b1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [5:0]         op,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               pcwrite,
  output logic               irwrite,
  output logic               memwrite,
  output logic               iord,
  output logic               regwrite,
  output logic               regdst,
  output logic               memtoreg,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic               immzext,
  output logic               branch,
  output logic               branch_ne,
  output logic [1:0]         pcsrc,
  output logic [ALUOP_W-1:0] aluop,
  output logic               illegal_op,
  output logic [3:0]         state_o
);

  state_t     state_r;
  state_t     next_state_s;
  logic       ready_s;
  logic [2:0] aluop_s;

  // Without the wait handshake every memory access completes in one cycle.
  assign ready_s = MEM_WAIT ? mem_ready : 1'b1;
  assign aluop   = ALUOP_W'(aluop_s);
  assign state_o = state_r;

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and output decode; everything reads 0 while reset is held.
  always_comb begin
    next_state_s = S_FETCH;
    mem_req      = 1'b0;
    pcwrite      = 1'b0;
    irwrite      = 1'b0;
    memwrite     = 1'b0;
    iord         = 1'b0;
    regwrite     = 1'b0;
    regdst       = 1'b0;
    memtoreg     = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = ALUSRCB_REGB;
    immzext      = 1'b0;
    branch       = 1'b0;
    branch_ne    = 1'b0;
    pcsrc        = PCSRC_ALU;
    aluop_s      = ALUOP_ADD;
    illegal_op   = 1'b0;
    if (reset_n) begin
      case (state_r)
        S_FETCH: begin
          alusrcb      = ALUSRCB_FOUR;
          mem_req      = 1'b1;
          irwrite      = ready_s;
          pcwrite      = ready_s;
          next_state_s = ready_s ? S_DECODE : S_FETCH;
        end
        S_DECODE: begin
          alusrcb = ALUSRCB_IMMSH;
          case (op)
            RTYPE:     next_state_s = S_EXECUTE;
            LW, SW:    next_state_s = S_MEMADR;
            BEQ, BNE:  next_state_s = S_BRANCH;
            ADDI:      next_state_s = S_ADDIEX;
            ORI, ANDI: next_state_s = S_LOGIEX;
            J:         next_state_s = S_JUMP;
            default: begin
              illegal_op   = 1'b1;
              next_state_s = S_FETCH;
            end
          endcase
        end
        S_MEMADR: begin
          alusrca      = 1'b1;
          alusrcb      = ALUSRCB_IMM;
          next_state_s = (op == SW) ? S_MEMWR : S_MEMRD;
        end
        S_MEMRD: begin
          iord         = 1'b1;
          mem_req      = 1'b1;
          next_state_s = ready_s ? S_MEMWB : S_MEMRD;
        end
        S_MEMWB: begin
          regwrite = 1'b1;
          memtoreg = 1'b1;
        end
        S_MEMWR: begin
          iord         = 1'b1;
          mem_req      = 1'b1;
          memwrite     = 1'b1;
          next_state_s = ready_s ? S_FETCH : S_MEMWR;
        end
        S_EXECUTE: begin
          alusrca      = 1'b1;
          aluop_s      = ALUOP_FUNCT;
          next_state_s = S_ALUWB;
        end
        S_ALUWB: begin
          regwrite = 1'b1;
          regdst   = 1'b1;
        end
        S_BRANCH: begin
          alusrca   = 1'b1;
          aluop_s   = ALUOP_SUB;
          pcsrc     = PCSRC_ALUOUT;
          branch    = (op == BEQ);
          branch_ne = (op == BNE);
        end
        S_ADDIEX: begin
          alusrca      = 1'b1;
          alusrcb      = ALUSRCB_IMM;
          next_state_s = S_IMMWB;
        end
        S_LOGIEX: begin
          alusrca      = 1'b1;
          alusrcb      = ALUSRCB_IMM;
          immzext      = 1'b1;
          aluop_s      = (op == ANDI) ? ALUOP_AND : ALUOP_OR;
          next_state_s = S_IMMWB;
        end
        S_IMMWB: begin
          regwrite = 1'b1;
        end
        S_JUMP: begin
          pcsrc   = PCSRC_JUMP;
          pcwrite = 1'b1;
        end
        default: begin
          next_state_s = S_FETCH;
        end
      endcase
    end else begin
      next_state_s = S_FETCH;
    end
  end

endmodule

// File: tb/tb_multicycle_maindec.sv
// Randomized scoreboard bench for multicycle_maindec: two instances (wait
// handshake honoured / ignored with a wide aluop) checked against a phase model.
module tb_multicycle_maindec;

  localparam logic [5:0] T_RTYPE = 6'b000000, T_LW = 6'b100011, T_SW = 6'b101011;
  localparam logic [5:0] T_BEQ = 6'b000100, T_BNE = 6'b000101, T_ADDI = 6'b001000;
  localparam logic [5:0] T_ORI = 6'b001101, T_ANDI = 6'b001100, T_J = 6'b000010;

  localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMRD = 3, P_MEMWB = 4;
  localparam int P_MEMWR = 5, P_EXEC = 6, P_ALUWB = 7, P_BRANCH = 8, P_ADDIEX = 9;
  localparam int P_LOGIEX = 10, P_IMMWB = 11, P_JUMP = 12;

  typedef struct packed {
    logic [3:0] st;
    logic       mem_req, pcwrite, irwrite, memwrite, iord, regwrite, regdst, memtoreg, alusrca;
    logic [1:0] alusrcb;
    logic       immzext, branch, branch_ne;
    logic [1:0] pcsrc;
    logic [4:0] aluop;
    logic       illegal;
  } exp_t;

  logic clk, rst0, rst1, mem_ready;
  logic [5:0] op0, op1;

  logic d0_mem_req, d0_pcwrite, d0_irwrite, d0_memwrite, d0_iord, d0_regwrite, d0_regdst;
  logic d0_memtoreg, d0_alusrca, d0_immzext, d0_branch, d0_branch_ne, d0_illegal;
  logic [1:0] d0_alusrcb, d0_pcsrc;
  logic [2:0] d0_aluop;
  logic [3:0] d0_state;

  logic d1_mem_req, d1_pcwrite, d1_irwrite, d1_memwrite, d1_iord, d1_regwrite, d1_regdst;
  logic d1_memtoreg, d1_alusrca, d1_immzext, d1_branch, d1_branch_ne, d1_illegal;
  logic [1:0] d1_alusrcb, d1_pcsrc;
  logic [4:0] d1_aluop;
  logic [3:0] d1_state;

  multicycle_maindec #(.ALUOP_W(3), .MEM_WAIT(1'b1)) dut0 (
    .clk(clk), .reset_n(rst0), .op(op0), .mem_ready(mem_ready),
    .mem_req(d0_mem_req), .pcwrite(d0_pcwrite), .irwrite(d0_irwrite), .memwrite(d0_memwrite),
    .iord(d0_iord), .regwrite(d0_regwrite), .regdst(d0_regdst), .memtoreg(d0_memtoreg),
    .alusrca(d0_alusrca), .alusrcb(d0_alusrcb), .immzext(d0_immzext), .branch(d0_branch),
    .branch_ne(d0_branch_ne), .pcsrc(d0_pcsrc), .aluop(d0_aluop), .illegal_op(d0_illegal),
    .state_o(d0_state)
  );

  multicycle_maindec #(.ALUOP_W(5), .MEM_WAIT(1'b0)) dut1 (
    .clk(clk), .reset_n(rst1), .op(op1), .mem_ready(mem_ready),
    .mem_req(d1_mem_req), .pcwrite(d1_pcwrite), .irwrite(d1_irwrite), .memwrite(d1_memwrite),
    .iord(d1_iord), .regwrite(d1_regwrite), .regdst(d1_regdst), .memtoreg(d1_memtoreg),
    .alusrca(d1_alusrca), .alusrcb(d1_alusrcb), .immzext(d1_immzext), .branch(d1_branch),
    .branch_ne(d1_branch_ne), .pcsrc(d1_pcsrc), .aluop(d1_aluop), .illegal_op(d1_illegal),
    .state_o(d1_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   failures = 0;
  bit   done = 1'b0;

  logic [5:0] legal_ops [9] = '{T_RTYPE, T_LW, T_SW, T_BEQ, T_BNE, T_ADDI, T_ORI, T_ANDI, T_J};

  function automatic bit is_legal(input logic [5:0] o);
    for (int i = 0; i < 9; i++) if (legal_ops[i] == o) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [5:0] rand_op();
    logic [5:0] r;
    if ($urandom_range(0, 4) == 0) r = 6'($urandom);
    else r = legal_ops[$urandom_range(0, 8)];
    return r;
  endfunction

  // Expected Moore outputs of each phase, as listed by the control table.
  function automatic exp_t model(input int ph, input logic [5:0] o, input logic rdy);
    exp_t e;
    e = '0;
    e.st = 4'(ph);
    case (ph)
      P_FETCH:  begin e.alusrcb = 2'b01; e.mem_req = 1'b1; e.irwrite = rdy; e.pcwrite = rdy; end
      P_DECODE: begin e.alusrcb = 2'b11; e.illegal = !is_legal(o); end
      P_MEMADR: begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
      P_MEMRD:  begin e.iord = 1'b1; e.mem_req = 1'b1; end
      P_MEMWB:  begin e.regwrite = 1'b1; e.memtoreg = 1'b1; end
      P_MEMWR:  begin e.iord = 1'b1; e.mem_req = 1'b1; e.memwrite = 1'b1; end
      P_EXEC:   begin e.alusrca = 1'b1; e.aluop = 5'd4; end
      P_ALUWB:  begin e.regwrite = 1'b1; e.regdst = 1'b1; end
      P_BRANCH: begin
        e.alusrca = 1'b1; e.aluop = 5'd1; e.pcsrc = 2'b01;
        e.branch = (o == T_BEQ); e.branch_ne = (o == T_BNE);
      end
      P_ADDIEX: begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
      P_LOGIEX: begin
        e.alusrca = 1'b1; e.alusrcb = 2'b10; e.immzext = 1'b1;
        e.aluop = (o == T_ANDI) ? 5'd3 : 5'd2;
      end
      P_IMMWB:  e.regwrite = 1'b1;
      P_JUMP:   begin e.pcsrc = 2'b10; e.pcwrite = 1'b1; end
      default:  e = '0;
    endcase
    return e;
  endfunction

  task automatic push(input int w, input exp_t e);
    if (w == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic cycle_start(input int w, input logic rst, input logic [5:0] o, input logic rdy);
    @(posedge clk);
    #1;
    if (w == 0) begin
      rst0 = rst; op0 = o; mem_ready = rdy;
    end else begin
      rst1 = rst; op1 = o;
    end
  endtask

  task automatic do_reset(input int w, input int cur, input int k);
    exp_t e;
    cycle_start(w, 1'b0, 6'b000000, 1'($urandom));
    e = '0; e.st = 4'(cur);
    push(w, e);
    for (int i = 1; i < k; i++) begin
      cycle_start(w, 1'b0, 6'b000000, 1'($urandom));
      push(w, exp_t'('0));
    end
  endtask

  // Drive one instruction through its phase list; fetch_wait < 0 means random waits.
  task automatic run_instr(input int w, input logic [5:0] o, input int fetch_wait, input int abort_at);
    int  phs[$];
    int  cyc;
    int  stalls;
    bit  mem_ph;
    logic rdy, eff;
    cyc = 0;
    phs.push_back(P_FETCH);
    phs.push_back(P_DECODE);
    if (o == T_RTYPE) begin phs.push_back(P_EXEC); phs.push_back(P_ALUWB); end
    else if (o == T_LW) begin phs.push_back(P_MEMADR); phs.push_back(P_MEMRD); phs.push_back(P_MEMWB); end
    else if (o == T_SW) begin phs.push_back(P_MEMADR); phs.push_back(P_MEMWR); end
    else if (o == T_BEQ || o == T_BNE) phs.push_back(P_BRANCH);
    else if (o == T_ADDI) begin phs.push_back(P_ADDIEX); phs.push_back(P_IMMWB); end
    else if (o == T_ORI || o == T_ANDI) begin phs.push_back(P_LOGIEX); phs.push_back(P_IMMWB); end
    else if (o == T_J) phs.push_back(P_JUMP);
    foreach (phs[i]) begin
      stalls = 0;
      mem_ph = (phs[i] == P_FETCH || phs[i] == P_MEMRD || phs[i] == P_MEMWR);
      do begin
        if (phs[i] == P_FETCH && fetch_wait >= 0) rdy = (stalls >= fetch_wait);
        else rdy = ($urandom_range(0, 99) < 65) || (stalls >= 4);
        eff = (w == 0) ? rdy : 1'b1;
        if (cyc == abort_at) begin
          do_reset(w, phs[i], 2);
          return;
        end
        cycle_start(w, 1'b1, o, rdy);
        push(w, model(phs[i], o, eff));
        cyc++;
        stalls++;
      end while (mem_ph && !eff);
    end
  endtask

  // Monitor: pop one expectation per DUT per cycle and compare; also ends the run.
  initial begin
    exp_t a0, a1, e0, e1;
    forever begin
      @(negedge clk);
      if (q0.size() > 0) begin
        e0 = q0.pop_front();
        a0 = {d0_state, d0_mem_req, d0_pcwrite, d0_irwrite, d0_memwrite, d0_iord, d0_regwrite,
              d0_regdst, d0_memtoreg, d0_alusrca, d0_alusrcb, d0_immzext, d0_branch,
              d0_branch_ne, d0_pcsrc, {2'b00, d0_aluop}, d0_illegal};
        checks++;
        if (a0 !== e0) begin
          failures++;
          $display("FAIL dut0_cycle t=%0t actual=%h expected=%h", $time, a0, e0);
        end
      end
      if (q1.size() > 0) begin
        e1 = q1.pop_front();
        a1 = {d1_state, d1_mem_req, d1_pcwrite, d1_irwrite, d1_memwrite, d1_iord, d1_regwrite,
              d1_regdst, d1_memtoreg, d1_alusrca, d1_alusrcb, d1_immzext, d1_branch,
              d1_branch_ne, d1_pcsrc, d1_aluop, d1_illegal};
        checks++;
        if (a1 !== e1) begin
          failures++;
          $display("FAIL dut1_cycle t=%0t actual=%h expected=%h", $time, a1, e1);
        end
      end
      if (done) begin
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
          failures++;
          $display("FAIL drain actual=%0d/%0d expected=0/0", q0.size(), q1.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst0 = 1'b0; rst1 = 1'b0; op0 = 6'b000000; op1 = 6'b000000; mem_ready = 1'b0;
    fork
      begin
        do_reset(0, P_FETCH, 3);
        run_instr(0, T_LW, 3, -1);
        run_instr(0, T_LW, 0, 3);
        run_instr(0, T_SW, 2, -1);
        run_instr(0, T_BEQ, 0, -1);
        run_instr(0, T_BNE, 0, -1);
        run_instr(0, T_ORI, 0, -1);
        run_instr(0, T_ANDI, 0, -1);
        run_instr(0, T_ADDI, 0, -1);
        run_instr(0, T_RTYPE, 0, -1);
        run_instr(0, T_J, 0, -1);
        run_instr(0, 6'b111111, 0, -1);
        for (int i = 0; i < 80; i++) run_instr(0, rand_op(), -1, ($urandom_range(0, 19) == 0) ? 2 : -1);
        run_instr(0, T_RTYPE, -1, -1);
      end
      begin
        do_reset(1, P_FETCH, 3);
        run_instr(1, T_LW, -1, -1);
        run_instr(1, T_J, -1, -1);
        run_instr(1, T_RTYPE, -1, -1);
        run_instr(1, T_SW, -1, 3);
        for (int k = 0; k < 50; k++) run_instr(1, rand_op(), -1, -1);
      end
    join
    @(posedge clk);
    #1;
    done = 1'b1;
  end

endmodule
